// File: rtl/sort_stream_checker.sv
// sort_stream_checker: receive-side checker for the odd-even sorter.
// Counts and sums one burst of N input beats, then checks that exactly N
// non-decreasing output beats come back with the same sum. Sticky error
// flags plus done/pass summarise each burst.
// Optional build macro: SORT_CHK_ERR_CAPTURE_EN adds first_err_idx and
// first_err_data, which record where the first ordering error occurred.
module sort_stream_checker #(
   parameter int N       = 128,
   parameter int W       = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [W-1:0]           in_data,
   input  logic                   out_valid,
   input  logic [W-1:0]           out_data,
   output logic                   done,
   output logic                   pass,
   output logic                   err_order,
   output logic                   err_count,
   output logic                   err_sum,
   output logic                   err_timeout,
   output logic [$clog2(N+1)-1:0] out_cnt
`ifdef SORT_CHK_ERR_CAPTURE_EN
   ,
   output logic [$clog2(N)-1:0]   first_err_idx,
   output logic [W-1:0]           first_err_data
`endif
);

   localparam int CW = $clog2(N+1);
   localparam int SW = W + $clog2(N) + 1;
   localparam int IW = $clog2(TIMEOUT+1);
   localparam logic [CW-1:0] CNT_N     = CW'(N);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT-1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t         r_state;
   logic [CW-1:0]  r_in_cnt;
   logic [CW-1:0]  r_out_cnt;
   logic [SW-1:0]  r_in_sum;
   logic [SW-1:0]  r_out_sum;
   logic [W-1:0]   r_prev;
   logic [IW-1:0]  r_idle_cnt;
   logic           r_done;
   logic           r_pass;
   logic           r_err_order;
   logic           r_err_count;
   logic           r_err_sum;
   logic           r_err_timeout;

   logic           w_out_first;
   logic           w_order_bad;
   logic [SW-1:0]  w_out_sum_next;
   logic [CW-1:0]  w_out_cnt_next;
   logic [SW-1:0]  w_in_sum_next;
   logic [CW-1:0]  w_in_cnt_next;
   logic           w_idle_expire;
   logic           w_sum_bad;

   // The first output beat of a burst seeds prev/sum instead of being compared.
   assign w_out_first    = (r_out_cnt == '0);
   assign w_order_bad    = out_valid && !w_out_first && (out_data < r_prev);
   assign w_out_sum_next = w_out_first ? SW'(out_data) : (r_out_sum + SW'(out_data));
   assign w_out_cnt_next = w_out_first ? CNT_ONE :
                           ((r_out_cnt == CNT_N) ? CNT_N : (r_out_cnt + CNT_ONE));
   assign w_in_sum_next  = r_in_sum + SW'(in_data);
   assign w_in_cnt_next  = r_in_cnt + CNT_ONE;
   assign w_idle_expire  = (r_idle_cnt == IDLE_LAST);
   assign w_sum_bad      = (r_in_sum != w_out_sum_next);

   // Burst-tracking FSM: counts/sums both streams and raises the sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_in_cnt      <= '0;
         r_out_cnt     <= '0;
         r_in_sum      <= '0;
         r_out_sum     <= '0;
         r_prev        <= '0;
         r_idle_cnt    <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_err_order   <= 1'b0;
         r_err_count   <= 1'b0;
         r_err_sum     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state  <= S_LOAD;
                  r_in_cnt <= CNT_ONE;
                  r_in_sum <= SW'(in_data);
               end else if (out_valid) begin
                  r_err_count <= 1'b1;
                  r_done      <= 1'b1;
                  r_pass      <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  r_in_cnt <= w_in_cnt_next;
                  r_in_sum <= w_in_sum_next;
                  if (w_in_cnt_next == CNT_N) begin
                     r_state    <= (w_out_first && !out_valid) ? S_WAIT : S_CHECK;
                     r_idle_cnt <= '0;
                  end
               end
               if (out_valid) begin
                  r_err_count <= 1'b1;
                  r_out_cnt   <= w_out_cnt_next;
                  r_out_sum   <= w_out_sum_next;
                  r_prev      <= out_data;
                  if (w_order_bad) r_err_order <= 1'b1;
               end
            end
            S_WAIT: begin
               if (in_valid) r_err_count <= 1'b1;
               if (out_valid) begin
                  r_state    <= S_CHECK;
                  r_out_cnt  <= w_out_cnt_next;
                  r_out_sum  <= w_out_sum_next;
                  r_prev     <= out_data;
                  r_idle_cnt <= '0;
               end else if (w_idle_expire) begin
                  r_err_timeout <= 1'b1;
                  r_done        <= 1'b1;
                  r_pass        <= 1'b0;
                  r_state       <= S_DONE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + IW'(1);
               end
            end
            S_CHECK: begin
               if (in_valid) r_err_count <= 1'b1;
               if (out_valid) begin
                  r_out_cnt  <= w_out_cnt_next;
                  r_out_sum  <= w_out_sum_next;
                  r_prev     <= out_data;
                  r_idle_cnt <= '0;
                  if (w_order_bad) r_err_order <= 1'b1;
                  if (w_out_cnt_next == CNT_N) begin
                     r_err_sum <= w_sum_bad;
                     r_pass    <= !(r_err_order | w_order_bad | r_err_count | in_valid |
                                    w_sum_bad | r_err_timeout);
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end else if (w_idle_expire) begin
                  r_err_timeout <= 1'b1;
                  r_done        <= 1'b1;
                  r_pass        <= 1'b0;
                  r_state       <= S_DONE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + IW'(1);
               end
            end
            S_DONE: begin
               if (in_valid) begin
                  r_state       <= S_LOAD;
                  r_in_cnt      <= CNT_ONE;
                  r_in_sum      <= SW'(in_data);
                  r_out_cnt     <= '0;
                  r_out_sum     <= '0;
                  r_prev        <= '0;
                  r_idle_cnt    <= '0;
                  r_done        <= 1'b0;
                  r_pass        <= 1'b0;
                  r_err_order   <= 1'b0;
                  r_err_count   <= 1'b0;
                  r_err_sum     <= 1'b0;
                  r_err_timeout <= 1'b0;
               end else if (out_valid) begin
                  r_err_count <= 1'b1;
                  r_pass      <= 1'b0;
                  r_out_cnt   <= w_out_cnt_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done        = r_done;
   assign pass        = r_pass;
   assign err_order   = r_err_order;
   assign err_count   = r_err_count;
   assign err_sum     = r_err_sum;
   assign err_timeout = r_err_timeout;
   assign out_cnt     = r_out_cnt;

`ifdef SORT_CHK_ERR_CAPTURE_EN
   localparam int IXW = $clog2(N);

   logic [IXW-1:0] r_first_err_idx;
   logic [W-1:0]   r_first_err_data;

   // Latch index and value of the first out-of-order beat of the burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_first_err_idx  <= '0;
         r_first_err_data <= '0;
      end else if (r_state == S_DONE && in_valid) begin
         r_first_err_idx  <= '0;
         r_first_err_data <= '0;
      end else if ((r_state == S_LOAD || r_state == S_CHECK) && w_order_bad && !r_err_order) begin
         r_first_err_idx  <= r_out_cnt[IXW-1:0];
         r_first_err_data <= out_data;
      end
   end

   assign first_err_idx  = r_first_err_idx;
   assign first_err_data = r_first_err_data;
`endif

endmodule
